// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sharing arbiter.
//   - one-hot ALU op encodings (ADD..SHL)
//   - default operand/opcode widths
//   - arbiter FSM state enum
//   - condition-code register bit indices {C,N,Z}
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 16;
  localparam int unsigned ALU_OP_W   = 8;
  localparam int unsigned ALU_SEL_W  = 7;
  localparam int unsigned CCR_W      = 3;

  localparam logic [ALU_SEL_W-1:0] OP_ADD = 7'b0000001;
  localparam logic [ALU_SEL_W-1:0] OP_SUB = 7'b0000010;
  localparam logic [ALU_SEL_W-1:0] OP_AND = 7'b0000100;
  localparam logic [ALU_SEL_W-1:0] OP_OR  = 7'b0001000;
  localparam logic [ALU_SEL_W-1:0] OP_NOT = 7'b0010000;
  localparam logic [ALU_SEL_W-1:0] OP_SHR = 7'b0100000;
  localparam logic [ALU_SEL_W-1:0] OP_SHL = 7'b1000000;

  localparam int unsigned CCR_Z = 0;
  localparam int unsigned CCR_N = 1;
  localparam int unsigned CCR_C = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when exactly one select bit is set.
  function automatic logic is_onehot(input logic [ALU_SEL_W-1:0] sel);
    return (sel != '0) && ((sel & (sel - ALU_SEL_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick2.sv
// rr_pick2: two-way grant picker for the ALU sharing arbiter.
// Build option: ALU_ARB_ROUND_ROBIN_EN
//   defined   - ties go to the port not granted last; pointer moves on each accept
//   undefined - fixed priority, port 0 always wins a tie (no pointer logic)
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   valid     per-port request present
//   accept    a grant was taken this cycle (updates the pointer)
//   grant     one-hot (or zero) grant decision, combinational
module rr_pick2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Last granted port; resets to port 1 so port 0 wins the first tie.
  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant[1];
    end
  end

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_fixed;
  assign unused_fixed = ^{clk, rst, accept};

  always_comb begin
    grant = {valid[1] & ~valid[0], valid[0]};
  end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between the execute stage
// (port 0) and the stack-pointer/address unit (port 1).
// Build option: ALU_ARB_ROUND_ROBIN_EN (round-robin tie break, see rr_pick2).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req<n>_valid/_ready      request handshake (ready is combinational)
//   req<n>_op/_a/_b          opcode ([7] ALU enable, [6:0] one-hot op), operands
//   rsp<n>_valid             one-cycle response strobe to the granted port
//   rsp_result, rsp_err      shared response payload
//   alu_op, alu_a, alu_b     registered drive to the ALU
//   alu_result, alu_flags    ALU outputs, captured at the end of EXEC
//   ccr                      condition codes {C,N,Z}, port-0 legal ALU ops only
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned OP_W   = ALU_OP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [OP_W-1:0]      req0_op,
  input  logic [DATA_W-1:0]    req0_a,
  input  logic [DATA_W-1:0]    req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [OP_W-1:0]      req1_op,
  input  logic [DATA_W-1:0]    req1_a,
  input  logic [DATA_W-1:0]    req1_b,
  output logic                 rsp0_valid,
  output logic                 rsp1_valid,
  output logic [DATA_W-1:0]    rsp_result,
  output logic                 rsp_err,
  output logic [ALU_SEL_W-1:0] alu_op,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic [CCR_W-1:0]     alu_flags,
  output logic [CCR_W-1:0]     ccr
);

  state_e state;
  state_e state_next;

  logic [1:0]          grant;
  logic                accept;
  logic [OP_W-1:0]     sel_op;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic                sel_en;
  logic                sel_legal;

  // Captured request attributes for the op in flight.
  logic                id_q;
  logic                bypass_q;
  logic                err_q;

  rr_pick2 u_pick (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  // Grant is offered in IDLE and DONE only; EXEC blocks both ports.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state != ST_EXEC) begin
      req0_ready = grant[0];
      req1_ready = grant[1];
    end
  end

  assign accept = req0_ready | req1_ready;

  // Select the granted request's payload and classify its opcode.
  always_comb begin
    sel_op    = grant[1] ? req1_op : req0_op;
    sel_a     = grant[1] ? req1_a  : req0_a;
    sel_b     = grant[1] ? req1_b  : req0_b;
    sel_en    = sel_op[ALU_OP_W-1];
    sel_legal = sel_en && is_onehot(sel_op[ALU_SEL_W-1:0]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_DONE;
      ST_DONE: state_next = accept ? ST_EXEC : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture, ALU drive and response/ccr capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q       <= 1'b0;
      bypass_q   <= 1'b0;
      err_q      <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      ccr        <= '0;
    end else begin
      alu_op     <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;

      if (accept) begin
        id_q     <= grant[1];
        bypass_q <= ~sel_en;
        err_q    <= sel_en & ~sel_legal;
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        // alu_op is non-zero only during the EXEC cycle of a legal op.
        alu_op   <= sel_legal ? sel_op[ALU_SEL_W-1:0] : '0;
      end

      if (state == ST_EXEC) begin
        rsp0_valid <= ~id_q;
        rsp1_valid <= id_q;
        rsp_err    <= err_q;
        if (bypass_q) begin
          rsp_result <= alu_a;
        end else if (err_q) begin
          rsp_result <= '0;
        end else begin
          rsp_result <= alu_result;
          if (!id_q) begin
            ccr <= alu_flags;
          end
        end
      end
    end
  end

endmodule
